disp_sched: RTL and testbench



---
 rtl/disp_sched_pkg.sv | 17 +
 rtl/disp_sched_rr_arb2.sv | 28 ++
 rtl/disp_sched.sv | 144 ++++++++++++++
 tb/tb_disp_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_sched_pkg.sv
// rtl/disp_sched_pkg.sv - shared types and constants for the display update scheduler
// Purpose: FSM state encoding, slot selector encoding and the default settle time.
// Ports: none (package).
package disp_sched_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  // Slot selector values carried on slot0/slot1
  localparam logic SLOT1 = 1'b0;  // z1/r1
  localparam logic SLOT2 = 1'b1;  // z2/r2

  localparam int HOLD_CYCLES_DEF = 4;

endpackage

// File: rtl/disp_sched_rr_arb2.sv
// rtl/disp_sched_rr_arb2.sv - two-requester round-robin arbiter (combinational)
// Purpose: pick one of two requesters; on a tie the one that did not win last time wins.
// Ports:
//   req[1:0]  in  request vector (bit n = channel n)
//   last_gnt  in  channel granted most recently (register held by the parent)
//   enable    in  arbitration allowed this cycle
//   gnt[1:0]  out one-hot grant, all-zero when disabled or idle
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       enable,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // Tie: favour the channel that is not last_gnt
        2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/disp_sched.sv
// rtl/disp_sched.sv - shares the seven-segment display between two result producers
// Purpose: round-robin grants z/r pairs into slot registers, blanks the scanner via busy
//          for HOLD_CYCLES cycles after every update or clear.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req0/slot0/z0_in/r0_in, ack0   channel 0 request, target slot, data, ack pulse
//   req1/slot1/z1_in/r1_in, ack1   channel 1 request, target slot, data, ack pulse
//   clr                            clear all display values (IDLE only)
//   busy                           high while an update/clear settles
//   z1/r1/z2/r2                    display holding registers
//   upd_cnt                        completed update count, wraps
module disp_sched
  import disp_sched_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int DW          = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          slot0,
  input  logic [DW-1:0] z0_in,
  input  logic [DW-1:0] r0_in,
  output logic          ack0,
  input  logic          req1,
  input  logic          slot1,
  input  logic [DW-1:0] z1_in,
  input  logic [DW-1:0] r1_in,
  output logic          ack1,
  input  logic          clr,
  output logic          busy,
  output logic [DW-1:0] z1,
  output logic [DW-1:0] r1,
  output logic [DW-1:0] z2,
  output logic [DW-1:0] r2,
  output logic [7:0]    upd_cnt
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t        r_state;
  logic          r_last_gnt;
  logic [7:0]    r_hold;
  logic          r_ack0;
  logic          r_ack1;
  logic          r_busy;
  logic [DW-1:0] r_z1;
  logic [DW-1:0] r_r1;
  logic [DW-1:0] r_z2;
  logic [DW-1:0] r_r2;
  logic [7:0]    r_upd_cnt;

  logic [1:0]    w_gnt;
  logic          w_enable;
  logic          w_slot;
  logic [DW-1:0] w_z;
  logic [DW-1:0] w_r;

  // clr outranks any request, so it also suppresses arbitration
  assign w_enable = (r_state == ST_IDLE) && !clr;

  rr_arb2 u_arb (
    .req      ({req1, req0}),
    .last_gnt (r_last_gnt),
    .enable   (w_enable),
    .gnt      (w_gnt)
  );

  // Data of the granted channel (only meaningful when w_gnt is non-zero)
  assign w_slot = w_gnt[1] ? slot1 : slot0;
  assign w_z    = w_gnt[1] ? z1_in : z0_in;
  assign w_r    = w_gnt[1] ? r1_in : r0_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= 1'b1;
      r_hold     <= 8'd0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_busy     <= 1'b0;
      r_z1       <= '0;
      r_r1       <= '0;
      r_z2       <= '0;
      r_r2       <= '0;
      r_upd_cnt  <= 8'd0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (clr) begin
            r_z1    <= '0;
            r_r1    <= '0;
            r_z2    <= '0;
            r_r2    <= '0;
            r_hold  <= HOLD_LOAD;
            r_busy  <= 1'b1;
            r_state <= ST_BLANK;
          end else if (w_gnt != 2'b00) begin
            case (w_slot)
              SLOT1: begin
                r_z1 <= w_z;
                r_r1 <= w_r;
              end
              SLOT2: begin
                r_z2 <= w_z;
                r_r2 <= w_r;
              end
              default: ;
            endcase
            r_last_gnt <= w_gnt[1];
            r_ack0     <= w_gnt[0];
            r_ack1     <= w_gnt[1];
            r_upd_cnt  <= r_upd_cnt + 8'd1;
            r_hold     <= HOLD_LOAD;
            r_busy     <= 1'b1;
            r_state    <= ST_BLANK;
          end
        end
        ST_BLANK: begin
          // Counter reaching zero ends the hold; busy drops on the same edge
          if (r_hold == 8'd0) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_hold <= r_hold - 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ack0    = r_ack0;
  assign ack1    = r_ack1;
  assign busy    = r_busy;
  assign z1      = r_z1;
  assign r1      = r_r1;
  assign z2      = r_z2;
  assign r2      = r_r2;
  assign upd_cnt = r_upd_cnt;

endmodule

// File: tb/tb_disp_sched.sv
// tb/tb_disp_sched.sv - self-checking bench for disp_sched
// Purpose: table of single-transaction vectors plus directed multi-cycle sequences;
//          a second instance with HOLD_CYCLES=1 covers the minimum settle time.
// Ports: none (top-level bench).
module tb_disp_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, slot0, req1, slot1, clr;
  logic [7:0] z0_in, r0_in, z1_in, r1_in;

  logic       d_ack0, d_ack1, d_busy;
  logic [7:0] d_z1, d_r1, d_z2, d_r2, d_upd;
  logic       h_ack0, h_ack1, h_busy;
  logic [7:0] h_z1, h_r1, h_z2, h_r2, h_upd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  disp_sched #(.HOLD_CYCLES(4), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .slot0(slot0), .z0_in(z0_in), .r0_in(r0_in), .ack0(d_ack0),
    .req1(req1), .slot1(slot1), .z1_in(z1_in), .r1_in(r1_in), .ack1(d_ack1),
    .clr(clr), .busy(d_busy),
    .z1(d_z1), .r1(d_r1), .z2(d_z2), .r2(d_r2), .upd_cnt(d_upd)
  );

  disp_sched #(.HOLD_CYCLES(1), .DW(8)) dut_h1 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .slot0(slot0), .z0_in(z0_in), .r0_in(r0_in), .ack0(h_ack0),
    .req1(req1), .slot1(slot1), .z1_in(z1_in), .r1_in(r1_in), .ack1(h_ack1),
    .clr(clr), .busy(h_busy),
    .z1(h_z1), .r1(h_r1), .z2(h_z2), .r2(h_r2), .upd_cnt(h_upd)
  );

  typedef struct {
    logic       req0;
    logic       slot0;
    logic [7:0] z0;
    logic [7:0] r0;
    logic       req1;
    logic       slot1;
    logic [7:0] z1i;
    logic [7:0] r1i;
    logic       clr;
    logic [7:0] ez1;
    logic [7:0] er1;
    logic [7:0] ez2;
    logic [7:0] er2;
    logic       eack0;
    logic       eack1;
    logic       ebusy;
    logic [7:0] eupd;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0 = 0; slot0 = 0; z0_in = 0; r0_in = 0;
    req1 = 0; slot1 = 0; z1_in = 0; r1_in = 0;
    clr = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int acks0, acks1, busy_n, run, max_run;
    int ack_cyc[$];
    int ack_ch[$];

    //            req0 s0 z0     r0     req1 s1 z1i    r1i    clr ez1    er1    ez2    er2    a0 a1 bsy upd
    vecs[0] = '{1'b1, 1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h12, 8'h34, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'd1};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h3C, 8'hC3, 1'b0, 8'h12, 8'h34, 8'h3C, 8'hC3, 1'b0, 1'b1, 1'b1, 8'd2};
    vecs[2] = '{1'b1, 1'b1, 8'hAA, 8'hBB, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h12, 8'h34, 8'hAA, 8'hBB, 1'b1, 1'b0, 1'b1, 8'd3};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h55, 8'h66, 1'b0, 8'h55, 8'h66, 8'hAA, 8'hBB, 1'b0, 1'b1, 1'b1, 8'd4};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'd4};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd4};
    vecs[6] = '{1'b1, 1'b0, 8'h77, 8'h88, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'd4};

    idle_inputs();
    do_reset();

    // Reset state
    chk("rst_busy", {31'd0, d_busy}, 0);
    chk("rst_ack", {30'd0, d_ack1, d_ack0}, 0);
    chk("rst_vals", {d_z1, d_r1, d_z2, d_r2}, 0);
    chk("rst_upd", {24'd0, d_upd}, 0);
    chk("rst_h1_busy", {31'd0, h_busy}, 0);

    // Table-driven single transactions, each starting from IDLE
    for (int i = 0; i < 7; i++) begin
      req0 = vecs[i].req0; slot0 = vecs[i].slot0; z0_in = vecs[i].z0; r0_in = vecs[i].r0;
      req1 = vecs[i].req1; slot1 = vecs[i].slot1; z1_in = vecs[i].z1i; r1_in = vecs[i].r1i;
      clr  = vecs[i].clr;
      @(posedge clk); #1;
      chk($sformatf("v%0d_z1", i), {24'd0, d_z1}, {24'd0, vecs[i].ez1});
      chk($sformatf("v%0d_r1", i), {24'd0, d_r1}, {24'd0, vecs[i].er1});
      chk($sformatf("v%0d_z2", i), {24'd0, d_z2}, {24'd0, vecs[i].ez2});
      chk($sformatf("v%0d_r2", i), {24'd0, d_r2}, {24'd0, vecs[i].er2});
      chk($sformatf("v%0d_ack0", i), {31'd0, d_ack0}, {31'd0, vecs[i].eack0});
      chk($sformatf("v%0d_ack1", i), {31'd0, d_ack1}, {31'd0, vecs[i].eack1});
      chk($sformatf("v%0d_busy", i), {31'd0, d_busy}, {31'd0, vecs[i].ebusy});
      chk($sformatf("v%0d_upd", i), {24'd0, d_upd}, {24'd0, vecs[i].eupd});
      idle_inputs();
      repeat (5) @(posedge clk);
      #1;
    end

    // First transaction timing: ack one cycle, busy exactly 4 cycles
    do_reset();
    req0 = 1; slot0 = 0; z0_in = 8'h12; r0_in = 8'h34;
    @(posedge clk); #1;
    chk("t1_ack0", {31'd0, d_ack0}, 1);
    chk("t1_busy0", {31'd0, d_busy}, 1);
    chk("t1_vals", {d_z1, d_r1, d_z2, d_r2}, 32'h1234_0000);
    chk("t1_upd", {24'd0, d_upd}, 1);
    req0 = 0;
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("t1_busy%0d", k), {31'd0, d_busy}, 1);
      chk($sformatf("t1_ack_off%0d", k), {31'd0, d_ack0}, 0);
    end
    @(posedge clk); #1;
    chk("t1_busy_end", {31'd0, d_busy}, 0);

    // Both requests held for 20 cycles: alternating grants at 5-cycle spacing
    do_reset();
    req0 = 1; slot0 = 0; z0_in = 8'hA5; r0_in = 8'h5A;
    req1 = 1; slot1 = 1; z1_in = 8'h3C; r1_in = 8'hC3;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (d_ack0) begin ack_cyc.push_back(c); ack_ch.push_back(0); end
      if (d_ack1) begin ack_cyc.push_back(c); ack_ch.push_back(1); end
    end
    idle_inputs();
    chk("rr_nacks", ack_cyc.size(), 4);
    for (int j = 0; j < 4 && j < ack_cyc.size(); j++) begin
      chk($sformatf("rr_cyc%0d", j), ack_cyc[j], 1 + 5 * j);
      chk($sformatf("rr_ch%0d", j), ack_ch[j], j % 2);
    end
    chk("rr_vals", {d_z1, d_r1, d_z2, d_r2}, 32'hA55A_3CC3);
    chk("rr_upd", {24'd0, d_upd}, 4);

    // clr during BLANK is lost
    @(posedge clk); #1;
    req0 = 1; slot0 = 0; z0_in = 8'h11; r0_in = 8'h22;
    @(posedge clk); #1;
    chk("cb_ack0", {31'd0, d_ack0}, 1);
    req0 = 0;
    @(posedge clk); #1;
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    chk("cb_vals", {d_z1, d_r1, d_z2, d_r2}, 32'h1122_3CC3);
    chk("cb_busy", {31'd0, d_busy}, 1);
    repeat (3) @(posedge clk); #1;
    chk("cb_idle", {31'd0, d_busy}, 0);
    chk("cb_vals2", {d_z1, d_r1, d_z2, d_r2}, 32'h1122_3CC3);
    chk("cb_upd", {24'd0, d_upd}, 5);

    // clr in IDLE with all slots nonzero
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    chk("ci_vals", {d_z1, d_r1, d_z2, d_r2}, 0);
    chk("ci_busy", {31'd0, d_busy}, 1);
    chk("ci_ack", {30'd0, d_ack1, d_ack0}, 0);
    chk("ci_upd", {24'd0, d_upd}, 5);
    repeat (3) @(posedge clk); #1;
    chk("ci_busy3", {31'd0, d_busy}, 1);
    @(posedge clk); #1;
    chk("ci_busy_end", {31'd0, d_busy}, 0);

    // Asynchronous reset in the second BLANK cycle; held req1 regranted after release
    req1 = 1; slot1 = 1; z1_in = 8'h9A; r1_in = 8'hBC;
    @(posedge clk); #1;
    chk("mr_ack1", {31'd0, d_ack1}, 1);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("mr_busy", {31'd0, d_busy}, 0);
    chk("mr_ack", {30'd0, d_ack1, d_ack0}, 0);
    chk("mr_vals", {d_z1, d_r1, d_z2, d_r2}, 0);
    chk("mr_upd", {24'd0, d_upd}, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("mr_regrant", {31'd0, d_ack1}, 1);
    chk("mr_z2", {24'd0, d_z2, d_r2}, 32'h9ABC);
    chk("mr_upd1", {24'd0, d_upd}, 1);
    idle_inputs();

    // 256 updates with HOLD_CYCLES=4: counter wraps, busy 4 of every 5 cycles
    do_reset();
    req0 = 1; slot0 = 0; z0_in = 8'h42; r0_in = 8'h24;
    acks0 = 0; busy_n = 0;
    for (int c = 1; c <= 1280; c++) begin
      @(posedge clk); #1;
      acks0 += int'(d_ack0);
      busy_n += int'(d_busy);
      if (c == 1275) chk("wr_upd255", {24'd0, d_upd}, 255);
    end
    idle_inputs();
    chk("wr_acks", acks0, 256);
    chk("wr_busy", busy_n, 1024);
    chk("wr_upd0", {24'd0, d_upd}, 0);

    // 256 updates with HOLD_CYCLES=1: busy exactly one cycle per update
    do_reset();
    req0 = 1; slot0 = 1; z0_in = 8'h5E; r0_in = 8'hE5;
    acks0 = 0; acks1 = 0; busy_n = 0; run = 0; max_run = 0;
    for (int c = 1; c <= 512; c++) begin
      @(posedge clk); #1;
      acks0 += int'(h_ack0);
      acks1 += int'(h_ack1);
      busy_n += int'(h_busy);
      run = h_busy ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (c == 510) chk("h1_upd255", {24'd0, h_upd}, 255);
    end
    idle_inputs();
    chk("h1_acks0", acks0, 256);
    chk("h1_acks1", acks1, 0);
    chk("h1_busy", busy_n, 256);
    chk("h1_maxrun", max_run, 1);
    chk("h1_upd0", {24'd0, h_upd}, 0);
    chk("h1_vals", {h_z1, h_r1, h_z2, h_r2}, 32'h0000_5EE5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
